// File: rtl/ram_burst_reader.sv
// Burst reader: fetches len consecutive words from a combinational-read RAM
// starting at start_addr (wrapping modulo depth) and streams them out on a
// valid/ready interface with a final-word marker and a completion pulse.
module ram_burst_reader #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned ASIZE     = 3
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 start,
  input  logic [ASIZE-1:0]     start_addr,
  input  logic [ASIZE:0]       len,
  output logic                 busy,
  output logic                 done,
  output logic                 ren,
  output logic [ASIZE-1:0]     raddr,
  input  logic [DATAWIDTH-1:0] rdata,
  output logic                 m_valid,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_last,
  input  logic                 m_ready
);

  localparam int unsigned LW = ASIZE + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ASIZE-1:0]     addr, addr_nxt;
  logic [LW-1:0]        remaining, rem_nxt;
  logic [DATAWIDTH-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 last_nxt;
  logic                 done_nxt;

  assign busy  = (state != IDLE);
  assign raddr = addr;

  // State and datapath registers with synchronous reset that aborts any burst
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= rem_nxt;
      m_data    <= data_nxt;
      m_valid   <= valid_nxt;
      m_last    <= last_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state, datapath loads and the RAM read enable for the current cycle
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rem_nxt   = remaining;
    data_nxt  = m_data;
    valid_nxt = m_valid;
    last_nxt  = m_last;
    done_nxt  = 1'b0;
    ren       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_nxt  = start_addr;
            rem_nxt   = len;
            state_nxt = READ;
          end else begin
            // Empty burst: nothing to read, just signal completion
            done_nxt = 1'b1;
          end
        end
      end
      READ: begin
        // Output register free or being emptied this cycle: capture next word
        if (!m_valid || m_ready) begin
          ren       = 1'b1;
          data_nxt  = rdata;
          valid_nxt = 1'b1;
          last_nxt  = (remaining == LW'(1));
          addr_nxt  = addr + ASIZE'(1);
          rem_nxt   = remaining - LW'(1);
          if (remaining == LW'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Final word is held until downstream accepts it
        if (m_valid && m_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: a RAM array feeds the DUT and a
// burst-level scoreboard predicts the word stream, done timing and busy.
module tb_ram_burst_reader;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rrst;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     len;
  logic            busy, done, ren, m_valid, m_last, m_ready;
  logic [AW-1:0]   raddr;
  logic [DW-1:0]   rdata, m_data;

  logic [DW-1:0]   mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  ram_burst_reader #(.DATAWIDTH(DW), .ASIZE(AW)) dut (
    .rclk(clk), .rrst(rrst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ren(ren), .raddr(raddr), .rdata(rdata),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  assign rdata = mem[raddr];

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (burst level) ----------------
  logic [DW-1:0] exp_q [$];
  bit            active    = 0;
  bit            done_pend = 0;
  bit            stall_prev = 0;
  logic [DW-1:0] held;
  int            age = 0;
  int            ren_cnt = 0;
  int            cur_len = 0;
  int            xfer_cnt = 0;

  // Sample away from the active edge and advance the model to the next edge
  always @(negedge clk) begin
    bit was_active;
    bit done_nxt;
    logic [DW-1:0] w;
    check("done", 32'(done), 32'(done_pend));
    check("busy", 32'(busy), 32'(active));
    if (!active) check("valid_idle", 32'(m_valid), 0);
    if (stall_prev) check("stable", 32'(m_data), 32'(held));
    if (age == 1) check("lat_first", 32'(m_valid), 0);
    if (age == 2) check("lat_valid", 32'(m_valid), 1);
    if (active && m_valid && !m_ready) check("ren_stall", 32'(ren), 0);
    if (ren) ren_cnt++;

    was_active = active;
    done_nxt   = 0;
    stall_prev = m_valid && !m_ready;
    held       = m_data;
    age        = (age != 0 && age < 3) ? age + 1 : 0;

    if (rrst) begin
      exp_q.delete();
      active = 0; done_pend = 0; age = 0; stall_prev = 0;
    end else begin
      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          w = exp_q.pop_front();
          check("data", 32'(m_data), 32'(w));
          check("last", 32'(m_last), 32'(exp_q.size() == 0));
          if (exp_q.size() == 0) begin
            active   = 0;
            done_nxt = 1;
            check("ren_count", 32'(ren_cnt), 32'(cur_len));
          end
        end
      end
      if (!was_active && start) begin
        if (len == 0) begin
          done_nxt = 1;
        end else begin
          for (int i = 0; i < int'(len); i++)
            exp_q.push_back(mem[(int'(start_addr) + i) % DEPTH]);
          active = 1; age = 1; ren_cnt = 0; cur_len = int'(len); xfer_cnt = 0;
        end
      end
      done_pend = done_nxt;
    end
  end

  // ---------------- stimulus ----------------
  int rmode = 0;
  int cyc   = 0;

  // Advance one cycle; inputs change just after the rising edge
  task automatic step();
    int p;
    @(posedge clk); #1;
    cyc++;
    p = cyc % 4;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = (p == 0 || p == 3);
    endcase
  endtask

  task automatic burst(input int sa, input int l, input bit poke);
    int n;
    start = 1'b1; start_addr = AW'(sa); len = (AW+1)'(l);
    step();
    start = 1'b0;
    n = 0;
    while (active && n < 200) begin
      if (poke && n == 2) begin
        start = 1'b1; start_addr = AW'($urandom); len = (AW+1)'($urandom_range(1, DEPTH));
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    if (active) check("timeout", 1, 0);
  endtask

  initial begin
    rrst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(16'h100 + i);
    step(); step();
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_raddr", 32'(raddr), 0);
    check("rst_ren", 32'(ren), 0);
    rrst = 1'b0;
    step();

    rmode = 0; burst(2, 4, 0);           // basic stream 0x102..0x105
    burst(7, 3, 0);                      // wrap 7,0,1
    burst(DEPTH-1, 2, 0);                // wrap at top
    rmode = 2; burst(0, 4, 0);           // stalled pattern
    rmode = 0; burst(3, 0, 0);           // empty burst
    step(); step();
    burst(1, DEPTH, 1);                  // start ignored while busy
    burst(4, 1, 0);                      // back to back after done

    // Reset after the second transfer of a len=8 burst
    start = 1'b1; start_addr = '0; len = (AW+1)'(8);
    step();
    start = 1'b0;
    for (int n = 0; n < 50 && xfer_cnt < 2; n++) step();
    check("rst_reach", 32'(xfer_cnt), 2);
    rrst = 1'b1; start = 1'b1; len = (AW+1)'(2);
    step();
    rrst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(m_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_last", 32'(m_last), 0);
    check("abort_raddr", 32'(raddr), 0);
    step();
    burst(5, 1, 0);                      // delivers 0x105

    // Randomised bursts over randomised RAM contents
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      rmode = $urandom_range(0, 2);
      burst($urandom_range(0, DEPTH-1), $urandom_range(0, DEPTH), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) step();
    end
    step(); step();
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 16, meaning word width of the RAM being read.
REQ-002 The module SHALL have parameter ASIZE, default 3, meaning RAM address width; depth is 2^ASIZE.
REQ-003 The module SHALL use one clock and a synchronous, active-high reset.
REQ-004 rclk  input  1  read-side clock; all state updates on its rising edge.
REQ-005 rrst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-007 start_addr  input  ASIZE  first RAM address of the burst.
REQ-008 len  input  ASIZE+1  number of words in the burst, 0..2^ASIZE.
REQ-009 busy  output  1  high while not in IDLE.
REQ-010 done  output  1  one-cycle pulse at burst completion.
REQ-011 ren  output  1  RAM read enable; high in every cycle a word is captured.
REQ-012 raddr  output  ASIZE  RAM read address, driven from the internal address register.
REQ-013 rdata  input  DATAWIDTH  RAM read data, combinational from raddr.
REQ-014 m_valid  output  1  output word valid.
REQ-015 m_data  output  DATAWIDTH  output word, registered.
REQ-016 m_last  output  1  qualifies the final word of the burst.
REQ-017 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.

Function
REQ-018 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-019 In IDLE, with start=1 and len>0: addr<=start_addr, remaining<=len, next state READ.
REQ-020 In IDLE, with start=1 and len=0: no data is produced and done pulses on the following cycle; state stays IDLE.
REQ-021 start SHALL be ignored in READ and DRAIN.
REQ-022 In READ, a load SHALL occur when m_valid=0 or m_ready=1.
REQ-023 On a load: ren=1, m_data<=rdata, m_valid<=1, m_last<=(remaining==1), addr<=addr+1 modulo 2^ASIZE, remaining<=remaining-1.
REQ-024 In READ, when m_valid=1 and m_ready=0, m_data, m_last, addr and remaining SHALL hold, and ren=0.
REQ-025 A load with remaining==1 SHALL move the FSM to DRAIN.
REQ-026 In READ, a transfer without a load SHALL clear m_valid; this case does not arise while remaining>0.
REQ-027 In DRAIN, ren=0; on a transfer: m_valid<=0, m_last<=0, done pulses on the next cycle, next state IDLE.
REQ-028 Address wrap SHALL be silent: start_addr=2^ASIZE-1 with len=2 reads 2^ASIZE-1 then 0.
REQ-029 Latency: start sampled at edge N gives m_valid high after edge N+1.
REQ-030 With m_ready held high, throughput SHALL be one word per cycle, with no bubbles inside a burst.
REQ-031 Bursts SHALL complete back to back: a new start is accepted in the cycle after done.
REQ-032 m_data SHALL be stable while m_valid=1 and m_ready=0.

Reset
REQ-033 While rrst=1 at an edge: state<=IDLE, m_valid=0, m_last=0, m_data=0, done=0, busy=0, ren=0, addr=0, remaining=0.
REQ-034 A reset in mid-burst SHALL abort the burst: words not yet delivered are discarded and done does not pulse.
REQ-035 rrst SHALL take priority over start in the same cycle.

Verification
REQ-036 RAM preloaded with mem[i]=0x100+i; start_addr=2, len=4, m_ready=1 -> m_data sequence 0x102, 0x103, 0x104, 0x105 on consecutive cycles; m_last only on 0x105; done one cycle after the last transfer.
REQ-037 start_addr=7, len=3 with ASIZE=3 -> reads addresses 7, 0, 1 (data 0x107, 0x100, 0x101).
REQ-038 len=4 with m_ready toggling 1,0,0,1,… -> no word lost or duplicated; m_data stable while stalled; ren=0 in stall cycles.
REQ-039 len=0 -> m_valid never rises; done pulses exactly once; busy stays 0.
REQ-040 rrst asserted after the second transfer of a len=8 burst -> next cycle m_valid=0, busy=0, no done; a subsequent start with len=1 at address 5 delivers 0x105.
REQ-041 start re-asserted while busy -> ignored; the burst count remains the original len.
